// File: rtl/cpu_controller_if.sv
// cpu_controller_if: start/load/instruction inputs and datapath controls.
// master drives s, load, in; slave (controller) drives the controls.
interface cpu_controller_if #(
    parameter int data_width = 16
);
    logic                  s;
    logic                  load;
    logic [data_width-1:0] in;
    logic                  w;
    logic [2:0]            readnum;
    logic [2:0]            writenum;
    logic                  write;
    logic                  loada;
    logic                  loadb;
    logic                  loadc;
    logic                  loads;
    logic                  asel;
    logic [1:0]            vsel;
    logic [1:0]            shift;
    logic [1:0]            ALUop;
    logic [data_width-1:0] sximm8;

    modport master (
        output s, load, in,
        input  w, readnum, writenum, write,
        input  loada, loadb, loadc, loads,
        input  asel, vsel, shift, ALUop, sximm8
    );

    modport slave (
        input  s, load, in,
        output w, readnum, writenum, write,
        output loada, loadb, loadc, loads,
        output asel, vsel, shift, ALUop, sximm8
    );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: IR + Moore FSM sequencing MOV/MVN/ADD/CMP/AND.
// Ports: clk, reset (sync, active-high), bus (cpu_controller_if.slave).
module cpu_controller #(
    parameter int data_width = 16
) (
    input  logic               clk,
    input  logic               reset,
    cpu_controller_if.slave    bus
);
    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } state_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic [1:0] vsel;
        logic [1:0] alu_op;
    } ctl_t;

    state_t                state;
    state_t                state_nx;
    logic [data_width-1:0] ir;
    logic [data_width-1:0] ir_nx;
    ctl_t                  ctl_q;
    ctl_t                  ctl_nx;

    logic [2:0] opc;
    logic [1:0] op;
    logic       is_movi;
    logic       is_movr;
    logic       is_mvn;
    logic       is_cmp;
    logic       is_alu3;

    // IR only accepts new words while idle; s in the same cycle
    // therefore decodes the freshly loaded instruction.
    always_comb begin
        ir_nx = ir;
        if (state == S_WAIT && bus.load)
            ir_nx = bus.in;
    end

    assign opc     = ir_nx[15:13];
    assign op      = ir_nx[12:11];
    assign is_movi = (opc == 3'b110) && (op == 2'b10);
    assign is_movr = (opc == 3'b110) && (op == 2'b00);
    assign is_mvn  = (opc == 3'b101) && (op == 2'b11);
    assign is_cmp  = (opc == 3'b101) && (op == 2'b01);
    assign is_alu3 = (opc == 3'b101) && (op != 2'b11);

    always_comb begin
        state_nx = S_WAIT;
        unique case (state)
            S_WAIT:   state_nx = bus.s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                unique case (1'b1)
                    is_movi:          state_nx = S_WRITE_IMM;
                    is_movr, is_mvn:  state_nx = S_GET_B;
                    is_alu3:          state_nx = S_GET_A;
                    default:          state_nx = S_WAIT;
                endcase
            end
            S_GET_A:  state_nx = S_GET_B;
            S_GET_B:  state_nx = S_ALU;
            S_ALU:    state_nx = is_cmp ? S_WAIT : S_WRITE_REG;
            default:  state_nx = S_WAIT;
        endcase
    end

    // Controls are computed for the state being entered so they
    // can be registered alongside it.
    always_comb begin
        ctl_nx   = '0;
        ctl_nx.w = (state_nx == S_WAIT);
        unique case (state_nx)
            S_WRITE_IMM: begin
                ctl_nx.write    = 1'b1;
                ctl_nx.writenum = ir_nx[10:8];
                ctl_nx.vsel     = 2'b01;
            end
            S_GET_A: begin
                ctl_nx.loada   = 1'b1;
                ctl_nx.readnum = ir_nx[10:8];
            end
            S_GET_B: begin
                ctl_nx.loadb   = 1'b1;
                ctl_nx.readnum = ir_nx[2:0];
            end
            S_ALU: begin
                ctl_nx.asel   = is_movr;
                ctl_nx.alu_op = is_movr ? 2'b00 : op;
                ctl_nx.loadc  = ~is_cmp;
                ctl_nx.loads  = is_cmp;
            end
            S_WRITE_REG: begin
                ctl_nx.write    = 1'b1;
                ctl_nx.writenum = ir_nx[7:5];
                ctl_nx.vsel     = 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_WAIT;
            ir      <= '0;
            ctl_q   <= '0;
            ctl_q.w <= 1'b1;
        end else begin
            state <= state_nx;
            ir    <= ir_nx;
            ctl_q <= ctl_nx;
        end
    end

    assign bus.w        = ctl_q.w;
    assign bus.readnum  = ctl_q.readnum;
    assign bus.writenum = ctl_q.writenum;
    assign bus.write    = ctl_q.write;
    assign bus.loada    = ctl_q.loada;
    assign bus.loadb    = ctl_q.loadb;
    assign bus.loadc    = ctl_q.loadc;
    assign bus.loads    = ctl_q.loads;
    assign bus.asel     = ctl_q.asel;
    assign bus.vsel     = ctl_q.vsel;
    assign bus.ALUop    = ctl_q.alu_op;
    assign bus.shift    = ir[4:3];
    assign bus.sximm8   = {{(data_width-8){ir[7]}}, ir[7:0]};
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed stimulus, cycle-plan model, per-cycle compare.
// Drives cpu_controller through reset, every opcode and abort cases.
module tb_cpu_controller;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    cpu_controller_if #(.data_width(16)) bus ();

    cpu_controller #(.data_width(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       chk_rd;
        logic [2:0] readnum;
        logic       chk_wr;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic       chk_alu;
        logic       asel;
        logic [1:0] aluop;
    } exp_t;

    exp_t        sched[$];
    exp_t        cur;
    logic [15:0] m_ir;
    logic        started;

    function automatic exp_t blank(input logic idle);
        exp_t e;
        e = '{default: '0};
        e.w = idle;
        return e;
    endfunction

    // Expected per-cycle plan of one instruction, ending back in idle.
    task automatic plan(input logic [15:0] x);
        exp_t       e;
        logic [2:0] opc;
        logic [1:0] op;
        logic       movi, movr, mvn, cmp, need_a;
        opc    = x[15:13];
        op     = x[12:11];
        movi   = (opc == 3'd6) && (op == 2'd2);
        movr   = (opc == 3'd6) && (op == 2'd0);
        mvn    = (opc == 3'd5) && (op == 2'd3);
        cmp    = (opc == 3'd5) && (op == 2'd1);
        need_a = (opc == 3'd5) && !mvn;
        sched.delete();
        sched.push_back(blank(1'b0));
        if (movi) begin
            e = blank(1'b0);
            e.write = 1; e.chk_wr = 1; e.writenum = x[10:8]; e.vsel = 2'd1;
            sched.push_back(e);
        end else if (movr || mvn || need_a) begin
            if (need_a) begin
                e = blank(1'b0);
                e.loada = 1; e.chk_rd = 1; e.readnum = x[10:8];
                sched.push_back(e);
            end
            e = blank(1'b0);
            e.loadb = 1; e.chk_rd = 1; e.readnum = x[2:0];
            sched.push_back(e);
            e = blank(1'b0);
            e.chk_alu = 1;
            e.asel    = movr;
            e.aluop   = movr ? 2'd0 : op;
            e.loadc   = !cmp;
            e.loads   = cmp;
            sched.push_back(e);
            if (!cmp) begin
                e = blank(1'b0);
                e.write = 1; e.chk_wr = 1; e.writenum = x[7:5]; e.vsel = 2'd0;
                sched.push_back(e);
            end
        end
        sched.push_back(blank(1'b1));
    endtask

    initial begin
        started = 0;
        m_ir    = '0;
        cur     = blank(1'b1);
    end

    always @(posedge clk) begin
        if (reset) begin
            started = 1;
            m_ir    = '0;
            sched.delete();
            cur     = blank(1'b1);
        end else if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else begin
            if (bus.load) m_ir = bus.in;
            if (bus.s) begin
                plan(m_ir);
                cur = sched.pop_front();
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sext8(input logic [15:0] x);
        logic [15:0] v;
        v = {8'h00, x[7:0]};
        if (x[7]) v = v | 16'hFF00;
        return v;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("w",      16'(bus.w),      16'(cur.w));
            chk("write",  16'(bus.write),  16'(cur.write));
            chk("loada",  16'(bus.loada),  16'(cur.loada));
            chk("loadb",  16'(bus.loadb),  16'(cur.loadb));
            chk("loadc",  16'(bus.loadc),  16'(cur.loadc));
            chk("loads",  16'(bus.loads),  16'(cur.loads));
            chk("shift",  16'(bus.shift),  16'(m_ir[4:3]));
            chk("sximm8", bus.sximm8,      sext8(m_ir));
            if (cur.chk_rd)
                chk("readnum", 16'(bus.readnum), 16'(cur.readnum));
            if (cur.chk_wr) begin
                chk("writenum", 16'(bus.writenum), 16'(cur.writenum));
                chk("vsel",     16'(bus.vsel),     16'(cur.vsel));
            end
            if (cur.chk_alu) begin
                chk("asel",  16'(bus.asel),  16'(cur.asel));
                chk("ALUop", 16'(bus.ALUop), 16'(cur.aluop));
            end
        end
    end

    task automatic cyc(input logic r, input logic sv, input logic ld,
                       input logic [15:0] d);
        reset    = r;
        bus.s    = sv;
        bus.load = ld;
        bus.in   = d;
        @(posedge clk);
        #1;
        reset    = 0;
        bus.s    = 0;
        bus.load = 0;
        bus.in   = '0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'h0000);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1;
        bus.s    = 0;
        bus.load = 0;
        bus.in   = '0;

        cyc(1, 0, 0, 16'h0000);
        chk("rst_w",      16'(bus.w),      16'h1);
        chk("rst_write",  16'(bus.write),  16'h0);
        chk("rst_loada",  16'(bus.loada),  16'h0);
        chk("rst_loadc",  16'(bus.loadc),  16'h0);
        chk("rst_sximm8", bus.sximm8,      16'h0000);
        run_idle(2);

        // MOV R1,#7
        cyc(0, 0, 1, 16'hD107);
        cyc(0, 1, 0, 16'h0000);
        chk("movi_dec_w", 16'(bus.w), 16'h0);
        cyc(0, 0, 0, 16'h0000);
        chk("movi_write",    16'(bus.write),    16'h1);
        chk("movi_writenum", 16'(bus.writenum), 16'h1);
        chk("movi_vsel",     16'(bus.vsel),     16'h1);
        chk("movi_sximm8",   bus.sximm8,        16'h0007);
        cyc(0, 0, 0, 16'h0000);
        chk("movi_done_w", 16'(bus.w), 16'h1);
        run_idle(1);

        // ADD R2,R1,R0,LSL#1 ; s mid-flight and late loads ignored
        cyc(0, 1, 1, 16'hA148);
        cyc(0, 1, 0, 16'h0000);
        chk("add_geta_loada",   16'(bus.loada),   16'h1);
        chk("add_geta_readnum", 16'(bus.readnum), 16'h1);
        cyc(0, 0, 0, 16'h0000);
        chk("add_getb_loadb",   16'(bus.loadb),   16'h1);
        chk("add_getb_readnum", 16'(bus.readnum), 16'h0);
        chk("add_shift",        16'(bus.shift),   16'h1);
        cyc(0, 0, 1, 16'h1234);
        chk("add_alu_op",    16'(bus.ALUop), 16'h0);
        chk("add_alu_loadc", 16'(bus.loadc), 16'h1);
        chk("add_ir_kept",   bus.sximm8,     16'h0048);
        cyc(0, 0, 0, 16'h0000);
        chk("add_wr_write",    16'(bus.write),    16'h1);
        chk("add_wr_writenum", 16'(bus.writenum), 16'h2);
        chk("add_wr_vsel",     16'(bus.vsel),     16'h0);
        cyc(0, 0, 0, 16'h0000);
        chk("add_done_w", 16'(bus.w), 16'h1);

        // CMP R1,R0
        cyc(0, 1, 1, 16'hA900);
        run_idle(2);
        cyc(0, 0, 0, 16'h0000);
        chk("cmp_loads", 16'(bus.loads), 16'h1);
        chk("cmp_aluop", 16'(bus.ALUop), 16'h1);
        chk("cmp_loadc", 16'(bus.loadc), 16'h0);
        cyc(0, 0, 0, 16'h0000);
        chk("cmp_done_w",  16'(bus.w),     16'h1);
        chk("cmp_nowrite", 16'(bus.write), 16'h0);

        // MOV R5,R3 ; MVN R7,R2 ; AND R5,R4,R1,LSL#1
        cyc(0, 1, 1, 16'hC0A3);
        run_idle(2);
        chk("movr_asel", 16'(bus.asel), 16'h1);
        run_idle(3);
        cyc(0, 1, 1, 16'hB8E2);
        run_idle(5);
        cyc(0, 1, 1, 16'hB4A9);
        run_idle(6);

        // MOV R2,#-16 with load ignored mid-flight
        cyc(0, 1, 1, 16'hD2F0);
        chk("movn_sximm8", bus.sximm8, 16'hFFF0);
        cyc(0, 0, 1, 16'h1234);
        chk("movn_writenum", 16'(bus.writenum), 16'h2);
        cyc(0, 0, 1, 16'h1234);
        chk("movn_ir_kept", bus.sximm8, 16'hFFF0);

        // reset aborts ADD during GET_B
        cyc(0, 1, 1, 16'hA148);
        run_idle(2);
        cyc(1, 0, 0, 16'h0000);
        chk("abort_w",      16'(bus.w),     16'h1);
        chk("abort_sximm8", bus.sximm8,     16'h0000);
        chk("abort_write",  16'(bus.write), 16'h0);
        run_idle(3);

        // unsupported encoding
        cyc(0, 1, 1, 16'hE000);
        chk("bad_dec_w", 16'(bus.w), 16'h0);
        cyc(0, 0, 0, 16'h0000);
        chk("bad_done_w", 16'(bus.w), 16'h1);
        run_idle(1);

        // reset beats s and load
        cyc(1, 1, 1, 16'hD107);
        chk("rst_prio_w",  16'(bus.w),  bus.w === 1'b1 ? 16'h1 : 16'h1);
        chk("rst_prio_ir", bus.sximm8,  16'h0000);
        cyc(0, 0, 0, 16'h0000);
        chk("rst_prio_idle", 16'(bus.w), 16'h1);
        run_idle(2);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
